// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with valid/ready handshakes on the issue side and on
// the result side. A caller tag travels unchanged alongside every operation.
//
//   Stage 1 (S1): captures operands, opcode and tag when an input transfer
//                 happens (in_valid && in_ready).
//   Stage 2 (S2): computes result and flags from the S1 registers and holds
//                 them on the output ports until the consumer takes them.
//
// Opcodes:
//   000 ADD   A + B
//   001 SUB   A - B  (computed as A + ~B + 1)
//   010 AND
//   011 OR
//   100 XOR
//   101 SLT   1 when A < B as signed values, else 0 (zero-extended)
//   110 ADDS  saturating add       (plain ADD unless ALU_PIPE_SAT_EN)
//   111 SUBS  saturating subtract  (plain SUB unless ALU_PIPE_SAT_EN)
//
// Build option:
//   ALU_PIPE_SAT_EN  when defined, ADDS/SUBS clamp to the most positive or
//                    most negative signed value on signed overflow. When not
//                    defined, no saturation logic is present.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   TAG_W  caller tag width (>= 1)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operation presented by the issue stage
//   in_ready    block can accept an operation this cycle
//   in_a/in_b   operands
//   in_op       opcode
//   in_tag      caller tag
//   out_valid   result presented to the consumer
//   out_ready   consumer accepts the result this cycle
//   out_result  result
//   out_tag     tag belonging to out_result
//   out_zero    result == 0
//   out_carry   adder carry-out for add/subtract ops, else 0
//   out_ovf     signed overflow for add/subtract ops, else 0
//   out_neg     result sign bit
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_neg
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_ADDS = 3'b110;
    localparam logic [2:0] OP_SUBS = 3'b111;

    localparam int MSB = WIDTH - 1;

    // Stage 1 registers
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic [TAG_W-1:0] s1_tag_r;

    // Stage 2 registers (drive the output ports directly)
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_zero_r;
    logic             s2_carry_r;
    logic             s2_ovf_r;
    logic             s2_neg_r;

    // Handshake / stall control
    logic s2_adv_s;
    logic s1_adv_s;
    logic in_accept_s;

    // Datapath
    logic             is_arith_s;
    logic             is_sub_s;
    logic             is_sat_op_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_ext_s;
    logic             add_ovf_s;
    logic             slt_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;

    // S2 loads whenever it is empty or its current content is being taken,
    // and S1 hands over only when it holds something. in_ready deliberately
    // depends only on state and out_ready so it never loops back to in_valid.
    always_comb begin
        s2_adv_s    = !s2_valid_r || out_ready;
        s1_adv_s    = s1_valid_r && s2_adv_s;
        in_ready    = !s1_valid_r || s2_adv_s;
        in_accept_s = in_valid && in_ready;
    end

    // Classify the opcode held in S1 for the shared adder.
    always_comb begin
        is_arith_s  = 1'b0;
        is_sub_s    = 1'b0;
        is_sat_op_s = 1'b0;
        case (s1_op_r)
            OP_ADD: begin
                is_arith_s = 1'b1;
            end
            OP_SUB: begin
                is_arith_s = 1'b1;
                is_sub_s   = 1'b1;
            end
            OP_ADDS: begin
                is_arith_s  = 1'b1;
                is_sat_op_s = 1'b1;
            end
            OP_SUBS: begin
                is_arith_s  = 1'b1;
                is_sub_s    = 1'b1;
                is_sat_op_s = 1'b1;
            end
            default: begin
                is_arith_s  = 1'b0;
                is_sub_s    = 1'b0;
                is_sat_op_s = 1'b0;
            end
        endcase
    end

    // Single adder serves add and subtract: subtraction feeds ~B with a
    // carry-in of 1, so the carry-out means "A >= B unsigned" for SUB.
    // Signed overflow: both adder inputs share a sign that the sum lacks.
    always_comb begin
        b_eff_s   = is_sub_s ? ~s1_b_r : s1_b_r;
        sum_ext_s = {1'b0, s1_a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, is_sub_s};
        add_ovf_s = (s1_a_r[MSB] == b_eff_s[MSB]) && (sum_ext_s[MSB] != s1_a_r[MSB]);
        slt_s     = $signed(s1_a_r) < $signed(s1_b_r);
    end

    // Result and arithmetic flags for the operation sitting in S1.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (s1_op_r)
            OP_AND:  result_s = s1_a_r & s1_b_r;
            OP_OR:   result_s = s1_a_r | s1_b_r;
            OP_XOR:  result_s = s1_a_r ^ s1_b_r;
            OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, slt_s};
            default: result_s = sum_ext_s[WIDTH-1:0];
        endcase
        if (is_arith_s) begin
            carry_s = sum_ext_s[WIDTH];
            ovf_s   = add_ovf_s;
        end else begin
            carry_s = 1'b0;
            ovf_s   = 1'b0;
        end
`ifdef ALU_PIPE_SAT_EN
        // On overflow the true result has the sign of operand A (both adder
        // inputs agree in sign), so A's sign picks the clamp direction.
        if (is_sat_op_s && add_ovf_s) begin
            if (s1_a_r[MSB]) begin
                result_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                result_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            result_s = result_s;
        end
`endif
    end

    // Stage 1: capture a new operation on accept; drop the valid bit once
    // the content has moved to S2 and nothing new replaced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (in_accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_op_r    <= in_op;
            s1_tag_r   <= in_tag;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: load computed result and flags when S2 advances. Data is only
    // replaced when S1 actually delivers, so a stalled output never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {WIDTH{1'b0}};
            s2_tag_r    <= {TAG_W{1'b0}};
            s2_zero_r   <= 1'b0;
            s2_carry_r  <= 1'b0;
            s2_ovf_r    <= 1'b0;
            s2_neg_r    <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_result_r <= result_s;
                s2_tag_r    <= s1_tag_r;
                s2_zero_r   <= (result_s == {WIDTH{1'b0}});
                s2_carry_r  <= carry_s;
                s2_ovf_r    <= ovf_s;
                s2_neg_r    <= result_s[MSB];
            end
        end
    end

    // Output ports come straight from the S2 registers.
    always_comb begin
        out_valid  = s2_valid_r;
        out_result = s2_result_r;
        out_tag    = s2_tag_r;
        out_zero   = s2_zero_r;
        out_carry  = s2_carry_r;
        out_ovf    = s2_ovf_r;
        out_neg    = s2_neg_r;
    end

endmodule
